// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush event counters for debug.
module if_id_hazard_reg #(
    parameter int                DATA_W    = 32,
    parameter int                REG_W     = 5,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    input  logic              id_ex_mem_read_i,
    input  logic [REG_W-1:0]  id_ex_rt_i,
    input  logic              flush_i,
    output logic              pc_write_o,
    output logic              bubble_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int               RS_LSB  = 21;
    localparam int               RT_LSB  = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             hazard;

    assign id_rs = instr_o[RS_LSB +: REG_W];
    assign id_rt = instr_o[RT_LSB +: REG_W];

    // A load writing $0 never creates a real dependency.
    assign hazard = valid_o & id_ex_mem_read_i & (id_ex_rt_i != '0)
                  & ((id_ex_rt_i == id_rs) | (id_ex_rt_i == id_rt));

    assign pc_write_o = ~hazard | flush_i;
    assign bubble_o   = hazard & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_o     <= NOP_INSTR;
            pc_plus4_o  <= '0;
            valid_o     <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (flush_i) begin
            instr_o    <= NOP_INSTR;
            pc_plus4_o <= '0;
            valid_o    <= 1'b0;
            if (flush_cnt_o != CNT_MAX)
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
        end else if (hazard) begin
            if (stall_cnt_o != CNT_MAX)
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end else begin
            instr_o    <= instr_i;
            pc_plus4_o <= pc_plus4_i;
            valid_o    <= 1'b1;
        end
    end

endmodule
